// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline sequencer state.
package cpu_types_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DDONE = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard comparator between ID/EX load and IF/ID sources.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     memread_ex,
    input  regbits_t rd_ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    input  logic     uses_rt_id,
    output logic     lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (rd_ex == rs_id);
    assign rt_hit = uses_rt_id & (rd_ex == rt_id);
    assign lu     = memread_ex & (rd_ex != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: memory wait, load-use, redirects,
// data-done tracking, halt latch and stall counter.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   dmemREN_mem,
    input  logic                   dmemWEN_mem,
    input  logic                   memread_ex,
    input  logic [REG_W-1:0]       rd_ex,
    input  logic [REG_W-1:0]       rs_id,
    input  logic [REG_W-1:0]       rt_id,
    input  logic                   uses_rt_id,
    input  logic                   branch_taken_ex,
    input  logic                   jump_id,
    input  logic                   halt_wb,
    output logic                   pipeline_control,
    output logic                   pc_en,
    output logic                   ifid_enable,
    output logic                   ifid_flush,
    output logic                   idex_enable,
    output logic                   idex_flush,
    output logic                   exmem_enable,
    output logic                   exmem_flush,
    output logic                   memwb_enable,
    output logic                   memwb_flush,
    output logic                   dmem_mask,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    ctrl_state_t state, state_nxt;
    logic        lu;
    logic        lu_apply;
    logic        memreq;
    logic        adv;
    logic        stall_inc;

    load_use_detect u_lu (
        .memread_ex (memread_ex),
        .rd_ex      (regbits_t'(rd_ex)),
        .rs_id      (regbits_t'(rs_id)),
        .rt_id      (regbits_t'(rt_id)),
        .uses_rt_id (uses_rt_id),
        .lu         (lu)
    );

    // Masking in DDONE keeps the finished access from being reissued.
    assign dmem_mask = (state == DDONE) & ~RST;
    assign memreq    = (dmemREN_mem | dmemWEN_mem) & ~dmem_mask;

    always_comb begin
        adv       = 1'b0;
        state_nxt = state;
        case (state)
            RUN: begin
                adv = ihit & (~memreq | dhit);
                if (halt_wb)
                    state_nxt = HALT;
                else if (memreq & dhit & ~ihit)
                    state_nxt = DDONE;
            end
            DDONE: begin
                adv = ihit;
                if (halt_wb)
                    state_nxt = HALT;
                else if (ihit)
                    state_nxt = RUN;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
        if (halt_wb | RST)
            adv = 1'b0;
    end

    assign pipeline_control = adv;
    assign lu_apply         = adv & ~branch_taken_ex & lu;
    assign stall_inc        = (state != HALT) & (~adv | lu_apply);
    assign exmem_flush      = 1'b0;
    assign memwb_flush      = 1'b0;

    always_comb begin
        pc_en        = 1'b0;
        ifid_enable  = 1'b0;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b0;
        idex_flush   = 1'b0;
        exmem_enable = 1'b0;
        memwb_enable = 1'b0;
        if (adv) begin
            exmem_enable = 1'b1;
            memwb_enable = 1'b1;
            idex_enable  = 1'b1;
            // Branch outranks load-use: the stalled consumer is flushed anyway.
            priority case (1'b1)
                branch_taken_ex: begin
                    pc_en       = 1'b1;
                    ifid_enable = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end
                lu: begin
                    idex_flush = 1'b1;
                end
                jump_id: begin
                    pc_en       = 1'b1;
                    ifid_enable = 1'b1;
                    ifid_flush  = 1'b1;
                end
                default: begin
                    pc_en       = 1'b1;
                    ifid_enable = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= RUN;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == HALT)
                halted <= 1'b1;
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with directed vectors.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 0, dhit = 0, ren = 0, wen = 0;
    logic        memread_ex = 0, uses_rt_id = 0;
    logic        branch_taken_ex = 0, jump_id = 0, halt_wb = 0;
    logic [4:0]  rd_ex = 0, rs_id = 0, rt_id = 0;
    logic        pipeline_control, pc_en;
    logic        ifid_enable, ifid_flush, idex_enable, idex_flush;
    logic        exmem_enable, exmem_flush, memwb_enable, memwb_flush;
    logic        dmem_mask, halted;
    logic [15:0] stall_cycles;

    typedef struct {
        string       nm;
        logic [9:0]  ctl;
        logic        mask;
        logic        hlt;
        logic [15:0] stall;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // {ctrl, pc, ifid_en, ifid_fl, idex_en, idex_fl, exm_en, exm_fl, mwb_en, mwb_fl}
    localparam logic [9:0] ZERO = 10'b0000000000;
    localparam logic [9:0] ADV  = 10'b1110101010;
    localparam logic [9:0] LUB  = 10'b1000111010;
    localparam logic [9:0] BRF  = 10'b1111111010;
    localparam logic [9:0] JMP  = 10'b1111101010;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.REG_W(5), .STALL_CNT_W(16)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ihit             (ihit),
        .dhit             (dhit),
        .dmemREN_mem      (ren),
        .dmemWEN_mem      (wen),
        .memread_ex       (memread_ex),
        .rd_ex            (rd_ex),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .uses_rt_id       (uses_rt_id),
        .branch_taken_ex  (branch_taken_ex),
        .jump_id          (jump_id),
        .halt_wb          (halt_wb),
        .pipeline_control (pipeline_control),
        .pc_en            (pc_en),
        .ifid_enable      (ifid_enable),
        .ifid_flush       (ifid_flush),
        .idex_enable      (idex_enable),
        .idex_flush       (idex_flush),
        .exmem_enable     (exmem_enable),
        .exmem_flush      (exmem_flush),
        .memwb_enable     (memwb_enable),
        .memwb_flush      (memwb_flush),
        .dmem_mask        (dmem_mask),
        .halted           (halted),
        .stall_cycles     (stall_cycles)
    );

    task automatic step(
        input string nm,
        input logic r, ih, dh, rn, wn, mr,
        input logic [4:0] rd, rs, rt,
        input logic ur, br, jp, hw,
        input logic [9:0] ec,
        input logic em, eh,
        input logic [15:0] es
    );
        exp_t e;
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dhit = dh; ren = rn; wen = wn;
        memread_ex = mr; rd_ex = rd; rs_id = rs; rt_id = rt;
        uses_rt_id = ur; branch_taken_ex = br; jump_id = jp;
        halt_wb = hw;
        e.nm = nm; e.ctl = ec; e.mask = em; e.hlt = eh; e.stall = es;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e = q.pop_front();
            act = {pipeline_control, pc_en, ifid_enable, ifid_flush,
                   idex_enable, idex_flush, exmem_enable, exmem_flush,
                   memwb_enable, memwb_flush};
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
            end
            tests++;
            if (dmem_mask !== e.mask) begin
                fails++;
                $display("FAIL %s mask: got %b want %b", e.nm, dmem_mask, e.mask);
            end
            tests++;
            if (halted !== e.hlt) begin
                fails++;
                $display("FAIL %s halted: got %b want %b", e.nm, halted, e.hlt);
            end
            tests++;
            if (stall_cycles !== e.stall) begin
                fails++;
                $display("FAIL %s stall: got %0d want %0d", e.nm, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        int wait_cyc;
        //     name      rst ih dh rn wn mr rd  rs  rt  ur br jp hw  ctl  msk hlt stall
        step("reset",    1, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step("plain",  0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 0);
        step("lu_rs",    0, 1, 0, 0, 0, 1, 8,  8,  0,  0, 0, 0, 0, LUB,  0, 0, 0);
        step("after_lu", 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 1);
        step("lu_rd0",   0, 1, 0, 0, 0, 1, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 1);
        step("lu_rt",    0, 1, 0, 0, 0, 1, 5,  3,  5,  1, 0, 0, 0, LUB,  0, 0, 1);
        step("rt_unused",0, 1, 0, 0, 0, 1, 5,  3,  5,  0, 0, 0, 0, ADV,  0, 0, 2);
        step("br_lu",    0, 1, 0, 0, 0, 1, 8,  8,  0,  0, 1, 0, 0, BRF,  0, 0, 2);
        step("jump",     0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 1, 0, JMP,  0, 0, 2);
        step("br_jmp",   0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 1, 1, 0, BRF,  0, 0, 2);
        step("st_dhit",  0, 0, 1, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 0, 2);
        step("ddone_w",  0, 0, 0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 1, 0, 3);
        step("ddone_ih", 0, 1, 0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  1, 0, 4);
        step("back_run", 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 4);
        step("ld_wait",  0, 1, 0, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 0, 4);
        step("ld_both",  0, 1, 1, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 5);
        step("stay_run", 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 5);
        step("st2_dhit", 0, 0, 1, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 0, 5);
        step("ddone2",   0, 0, 0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 1, 0, 6);
        step("rst_ddone",1, 1, 0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 0, 0);
        step("post_rst", 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ADV,  0, 0, 0);
        step("halt",     0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 1, ZERO, 0, 0, 0);
        step("halted1",  0, 1, 1, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 1, 1);
        step("halted2",  0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, ZERO, 0, 1, 1);
        step("halt_br",  0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 1, 0, 0, ZERO, 0, 1, 1);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge CLK);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
